icache_line_buf: RTL and testbench

ICACHE_LINE_BUF -- requirements
Module: icache_line_buf

---
 rtl/cache_defs_pkg.sv | 26 ++
 rtl/icache_line_buf_ctrl.sv | 105 ++++++++++
 rtl/icache_line_buf.sv | 98 +++++++++
 tb/tb_icache_line_buf.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_defs_pkg.sv
// Shared types for the instruction-fetch / line-buffer boundary.
// Widths of the fetch bundles follow CD_XLEN.
package cache_defs;

    localparam int unsigned LINE_WORDS_DEF = 4;
    localparam int unsigned CD_XLEN        = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        RESP   = 2'd2
    } icache_state_e;

    typedef struct packed {
        logic [CD_XLEN-1:0] addr;
        logic               req;
        logic               req_kill;
        logic               icache_flush;
    } type_if2icache_s;

    typedef struct packed {
        logic [CD_XLEN-1:0] r_data;
        logic               ack;
    } type_icache2if_s;

endpackage

// File: rtl/icache_line_buf_ctrl.sv
// Sequencer for the line buffer: request acceptance, in-order beat
// counting, and the kill/flush flags that ride along with a refill.
module icache_line_buf_ctrl
    import cache_defs::*;
#(
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_i,
    input  logic                          kill_i,
    input  logic                          flush_i,
    input  logic                          hit_i,
    input  logic                          mem_ack_i,
    output icache_state_e                 state_o,
    output logic [$clog2(LINE_WORDS)-1:0] beat_o,
    output logic                          accept_o,
    output logic                          fill_we_o,
    output logic                          fill_done_o,
    output logic                          set_valid_o,
    output logic                          ack_o,
    output logic                          mem_req_o
);

    localparam int unsigned   BW        = $clog2(LINE_WORDS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

    icache_state_e state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          kill_q, kill_d;
    logic          flush_q, flush_d;
    logic          hit_q, hit_d;
    logic          accept, fill_we, fill_done;

    // No new request while a hit ack is on the bus, so acks never abut.
    assign accept    = (state_q == IDLE) && req_i && !kill_i && !hit_q;
    assign fill_we   = !rst && (state_q == REFILL) && mem_ack_i;
    assign fill_done = fill_we && (beat_q == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !hit_i) state_d = REFILL;
            REFILL:  if (fill_done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        beat_d  = beat_q;
        kill_d  = kill_q;
        flush_d = flush_q;
        hit_d   = accept && hit_i;
        if (accept) begin
            beat_d  = '0;
            kill_d  = 1'b0;
            flush_d = 1'b0;
        end
        if (state_q == REFILL) begin
            kill_d  = kill_q | kill_i;
            flush_d = flush_q | flush_i;
            if (fill_we) beat_d = beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q  <= '0;
            kill_q  <= 1'b0;
            flush_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            beat_q  <= beat_d;
            kill_q  <= kill_d;
            flush_q <= flush_d;
            hit_q   <= hit_d;
        end
    end

    always_comb begin
        ack_o       = 1'b0;
        mem_req_o   = 1'b0;
        set_valid_o = fill_done && !(flush_q || flush_i);
        if (!rst) begin
            ack_o     = !kill_i && (hit_q || (state_q == RESP && !kill_q));
            mem_req_o = (state_q == REFILL);
        end
    end

    assign state_o     = state_q;
    assign beat_o      = beat_q;
    assign accept_o    = accept;
    assign fill_we_o   = fill_we;
    assign fill_done_o = fill_done;

endmodule

// File: rtl/icache_line_buf.sv
// Single-line instruction buffer refilled beat by beat from memory.
// Holds line storage, tag/valid, hit compare and the response mux.
module icache_line_buf
    import cache_defs::*;
#(
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
    parameter int unsigned XLEN       = CD_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  type_if2icache_s if2icache_i,
    output type_icache2if_s icache2if_o,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_ack_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam int unsigned BW  = $clog2(LINE_WORDS);
    localparam int unsigned OFF = BW + 2;

    icache_state_e       state;
    logic [BW-1:0]       beat;
    logic                accept, fill_we, fill_done, set_valid;
    logic                ack, hit;

    logic [XLEN-1:0]     line_q [LINE_WORDS];
    logic [XLEN-OFF-1:0] tag_q, tag_d;
    logic                valid_q, valid_d;
    logic [XLEN-1:2]     req_addr_q, req_addr_d;
    logic [XLEN-1:0]     r_data_q, r_data_d;
    logic [BW-1:0]       word_idx;
    logic                unused_addr_lsb;

    assign unused_addr_lsb = ^if2icache_i.addr[1:0];
    assign word_idx        = req_addr_q[OFF-1:2];

    // A flush in the same cycle forces the request down the miss path.
    assign hit = valid_q && !if2icache_i.icache_flush
              && (tag_q == if2icache_i.addr[XLEN-1:OFF]);

    icache_line_buf_ctrl #(
        .LINE_WORDS(LINE_WORDS)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .req_i      (if2icache_i.req),
        .kill_i     (if2icache_i.req_kill),
        .flush_i    (if2icache_i.icache_flush),
        .hit_i      (hit),
        .mem_ack_i  (mem_ack_i),
        .state_o    (state),
        .beat_o     (beat),
        .accept_o   (accept),
        .fill_we_o  (fill_we),
        .fill_done_o(fill_done),
        .set_valid_o(set_valid),
        .ack_o      (ack),
        .mem_req_o  (mem_req_o)
    );

    always_comb begin
        req_addr_d = accept ? if2icache_i.addr[XLEN-1:2] : req_addr_q;
        tag_d      = tag_q;
        valid_d    = valid_q;
        if (if2icache_i.icache_flush && state != REFILL) valid_d = 1'b0;
        if (fill_done) begin
            tag_d   = req_addr_q[XLEN-1:OFF];
            valid_d = set_valid;
        end
        r_data_d = ack ? line_q[word_idx] : r_data_q;
        if (rst) r_data_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q      <= '0;
            valid_q    <= 1'b0;
            req_addr_q <= '0;
            r_data_q   <= '0;
        end else begin
            tag_q      <= tag_d;
            valid_q    <= valid_d;
            req_addr_q <= req_addr_d;
            r_data_q   <= r_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) line_q[beat] <= mem_rdata_i;
    end

    assign mem_addr_o = mem_req_o ? {req_addr_q[XLEN-1:OFF], beat, 2'b00} : '0;

    assign icache2if_o.r_data = r_data_d;
    assign icache2if_o.ack    = ack;

endmodule

// File: tb/tb_icache_line_buf.sv
// Directed and randomized bench for icache_line_buf; a line-level
// reference model is compared against the DUT on every cycle.
module tb_icache_line_buf;
    import cache_defs::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            req, kill, flush;
    logic [31:0]     addr;
    type_if2icache_s if_i;
    type_icache2if_s if_o;
    logic            mem_req, mem_ack;
    logic [31:0]     mem_addr, mem_rdata;

    int          checks = 0, failures = 0, dut_acks = 0;
    int          mem_lat = 2, mcnt = 0;
    logic [31:0] salt = 32'h0;
    bit          mreq_seen = 0;
    bit          run_chk = 0;
    logic [31:0] beat_log [$];

    assign if_i = '{addr: addr, req: req, req_kill: kill, icache_flush: flush};

    always #5 clk = ~clk;

    icache_line_buf dut (
        .clk        (clk),
        .rst        (rst),
        .if2icache_i(if_i),
        .icache2if_o(if_o),
        .mem_req_o  (mem_req),
        .mem_addr_o (mem_addr),
        .mem_ack_i  (mem_ack),
        .mem_rdata_i(mem_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] qat(input int i);
        return (i < beat_log.size()) ? beat_log[i] : 32'hDEAD_DEAD;
    endfunction

    // Memory: each beat is acked after mem_lat cycles of request; data = addr ^ salt.
    always @(posedge clk) begin
        #2;
        if (mem_req) begin
            mreq_seen = 1;
            if (mcnt + 1 >= mem_lat) begin
                mem_ack = 1'b1;
                mcnt    = 0;
                beat_log.push_back(mem_addr);
            end else begin
                mem_ack = 1'b0;
                mcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            mcnt    = 0;
        end
        mem_rdata = mem_addr ^ salt;
    end

    // Reference model of the line and the outstanding fetch.
    bit          m_fill, m_resp, m_hit_pend, m_valid, m_killed, m_flushed;
    int          m_cnt;
    logic [31:0] m_addr, m_line_base, m_last;
    logic [31:0] m_line [4];
    logic        prev_ack;

    always @(negedge clk) begin
        logic        e_ack, e_mreq, nxt_hit;
        logic [31:0] e_rdata, e_maddr;
        if (run_chk) begin
            if (rst) begin
                e_ack = 0; e_mreq = 0; e_rdata = 0; e_maddr = 0;
            end else begin
                e_ack   = !kill && (m_hit_pend || (m_resp && !m_killed));
                e_rdata = e_ack ? m_line[(m_addr >> 2) % 4] : m_last;
                e_mreq  = m_fill;
                e_maddr = m_fill ? (m_addr & ~32'hF) + 32'(m_cnt * 4) : 32'h0;
            end
            chk("ack", {31'b0, if_o.ack}, {31'b0, e_ack});
            chk("r_data", if_o.r_data, e_rdata);
            chk("mem_req", {31'b0, mem_req}, {31'b0, e_mreq});
            chk("mem_addr", mem_addr, e_maddr);
            if (if_o.ack) begin
                dut_acks++;
                chk("ack_back_to_back", {31'b0, prev_ack}, 32'h0);
            end
            prev_ack = if_o.ack;

            if (rst) begin
                m_fill = 0; m_resp = 0; m_hit_pend = 0; m_valid = 0;
                m_killed = 0; m_flushed = 0; m_cnt = 0; m_last = 0;
            end else begin
                m_last  = e_rdata;
                nxt_hit = 0;
                if (m_fill) begin
                    m_killed  |= kill;
                    m_flushed |= flush;
                    if (mem_ack) begin
                        m_line[m_cnt] = mem_rdata;
                        m_cnt++;
                        if (m_cnt == 4) begin
                            m_fill      = 0;
                            m_resp      = 1;
                            m_line_base = m_addr & ~32'hF;
                            m_valid     = !m_flushed;
                        end
                    end
                end else if (m_resp) begin
                    if (flush) m_valid = 0;
                    m_resp = 0;
                end else begin
                    if (req && !kill && !m_hit_pend) begin
                        m_addr = addr;
                        if (!flush && m_valid && (addr & ~32'hF) == m_line_base) begin
                            nxt_hit = 1;
                        end else begin
                            m_fill = 1; m_cnt = 0; m_killed = 0; m_flushed = 0;
                        end
                    end
                    if (flush) m_valid = 0;
                end
                m_hit_pend = nxt_hit;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        kill  = 0;
        flush = 0;
    endtask

    task automatic wait_ack(input int budget, output logic got, output logic [31:0] d,
                            output int lat);
        got = 0; d = 0; lat = -1;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge clk);
            if (if_o.ack) begin
                got = 1; d = if_o.r_data; lat = n;
            end
            tick();
        end
        req = 0;
    endtask

    task automatic fetch(input logic [31:0] a, output logic got, output logic [31:0] d,
                         output int lat);
        addr = a;
        req  = 1;
        wait_ack(30, got, d, lat);
    endtask

    task automatic wait_addr(input logic [31:0] a, input int budget, output logic ok);
        ok = 0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            if (mem_req && mem_addr == a) ok = 1;
            tick();
        end
    endtask

    initial begin
        logic        got, ok;
        logic [31:0] d;
        int          lat, a0;
        rst = 1; req = 0; kill = 0; flush = 0; addr = 0; run_chk = 1;
        @(negedge clk);
        chk("rst_ack", {31'b0, if_o.ack}, 32'h0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_r_data", if_o.r_data, 32'h0);
        repeat (2) tick();
        rst = 0;
        repeat (2) tick();

        // Cold miss, 2-cycle beats
        salt = 32'h1111_0000;
        beat_log.delete();
        fetch(32'h8000_0004, got, d, lat);
        chk("cold_got", {31'b0, got}, 32'h1);
        chk("cold_lat", lat, 9);
        chk("cold_data", d, 32'h9111_0004);
        chk("cold_beats", beat_log.size(), 4);
        chk("cold_beat0", qat(0), 32'h8000_0000);
        chk("cold_beat1", qat(1), 32'h8000_0004);
        chk("cold_beat2", qat(2), 32'h8000_0008);
        chk("cold_beat3", qat(3), 32'h8000_000C);

        // Hit
        mreq_seen = 0;
        fetch(32'h8000_000C, got, d, lat);
        chk("hit_lat", lat, 1);
        chk("hit_data", d, 32'h9111_000C);
        chk("hit_no_mem", {31'b0, mreq_seen}, 32'h0);

        // Kill during beat 1
        salt = 32'h2222_0000;
        beat_log.delete();
        a0   = dut_acks;
        addr = 32'h8000_0010;
        req  = 1;
        wait_addr(32'h8000_0014, 20, ok);
        chk("kill_reach_beat1", {31'b0, ok}, 32'h1);
        kill = 1;
        req  = 0;
        repeat (14) tick();
        chk("kill_no_ack", dut_acks, a0);
        chk("kill_beats", beat_log.size(), 4);
        fetch(32'h8000_0014, got, d, lat);
        chk("kill_then_hit_lat", lat, 1);
        chk("kill_then_hit_data", d, 32'hA222_0014);

        // Flush in idle
        flush = 1;
        tick();
        salt = 32'h3333_0000;
        beat_log.delete();
        fetch(32'h8000_0014, got, d, lat);
        chk("flush_lat", lat, 9);
        chk("flush_data", d, 32'hB333_0014);
        chk("flush_beats", beat_log.size(), 4);
        chk("flush_beat0", qat(0), 32'h8000_0010);

        // Flush during refill
        addr = 32'h8000_0020;
        req  = 1;
        wait_addr(32'h8000_0024, 20, ok);
        chk("fr_reach_beat1", {31'b0, ok}, 32'h1);
        flush = 1;
        wait_ack(20, got, d, lat);
        chk("fr_got", {31'b0, got}, 32'h1);
        chk("fr_data", d, 32'hB333_0020);
        fetch(32'h8000_0020, got, d, lat);
        chk("fr_refetch_lat", lat, 9);

        // Reset mid-refill
        salt = 32'h4444_0000;
        addr = 32'h8000_0030;
        req  = 1;
        wait_addr(32'h8000_003C, 20, ok);
        chk("rr_reach_beat3", {31'b0, ok}, 32'h1);
        rst = 1;
        req = 0;
        @(negedge clk);
        chk("rr_in_rst_mem_req", {31'b0, mem_req}, 32'h0);
        tick();
        rst = 0;
        @(negedge clk);
        chk("rr_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rr_ack", {31'b0, if_o.ack}, 32'h0);
        chk("rr_r_data", if_o.r_data, 32'h0);
        tick();
        beat_log.delete();
        fetch(32'h8000_0030, got, d, lat);
        chk("rr_lat", lat, 9);
        chk("rr_beat0", qat(0), 32'h8000_0030);
        chk("rr_data", d, 32'hC444_0030);

        // Randomized req/kill/flush; the per-cycle model does the checking
        begin
            logic last_ack = 0;
            for (int i = 0; i < 400; i++) begin
                if (!req || last_ack) begin
                    req  = ($urandom % 3) != 0;
                    addr = 32'h8000_0000 + 32'(($urandom % 16) * 4);
                end
                kill    = ($urandom % 10) == 0;
                flush   = ($urandom % 12) == 0;
                mem_lat = 1 + int'($urandom % 3);
                if ($urandom % 8 == 0) salt = $urandom;
                @(negedge clk);
                last_ack = if_o.ack;
                @(posedge clk);
                #1;
            end
        end
        req = 0; kill = 0; flush = 0;
        repeat (20) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
